// File: rtl/multi_stream_reader.sv
// multi_stream_reader: N-channel AXI line reader unpacking lines into per-channel word streams; define MSR_FIXED_PRIO_EN for fixed-priority AR arbitration
module multi_stream_reader #(
  parameter int NUM_CH = 3,
  parameter int WORD_W = 64,
  parameter int LINE_W = 512,
  parameter int ADDR_W = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        start,
  input  logic [NUM_CH*ADDR_W-1:0] base_addr,
  input  logic [NUM_CH*CNT_W-1:0]  word_count,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        done,
  output logic                     err,
  output logic [15:0]              arid_m,
  output logic [ADDR_W-1:0]        araddr_m,
  output logic [7:0]               arlen_m,
  output logic [2:0]               arsize_m,
  output logic                     arvalid_m,
  input  logic                     arready_m,
  input  logic [15:0]              rid_m,
  input  logic [LINE_W-1:0]        rdata_m,
  input  logic                     rvalid_m,
  output logic                     rready_m,
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH*WORD_W-1:0] out_data,
  input  logic [NUM_CH-1:0]        out_ready
);
  localparam int WPL = LINE_W / WORD_W;
  localparam int OB = $clog2(LINE_W / 8);
  localparam int WB = $clog2(WORD_W / 8);
  localparam int LW = $clog2(WPL);
  localparam int IW = WPL > 1 ? LW : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} st_t;
  logic [NUM_CH-1:0] elig, issue, push;
  logic [ADDR_W-1:0] ch_addr [NUM_CH];
  logic [CHW-1:0] gnt;
  logic gnt_any, ok;
  assign arlen_m = '0;
  assign arsize_m = 3'(OB);
  assign rready_m = 1'b1;
  assign ok = gnt_any && (!arvalid_m || arready_m);
  assign issue = ok ? NUM_CH'(1) << gnt : '0;
`ifdef MSR_FIXED_PRIO_EN
  always_comb begin
    gnt_any = 1'b0;
    gnt = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (elig[i]) begin
        gnt_any = 1'b1;
        gnt = CHW'(i);
      end
  end
`else
  logic [CHW-1:0] last_g;
  logic [2*NUM_CH-1:0] elig2;
  assign elig2 = {elig, elig};
  // descending scan so the first eligible channel after last_g wins
  always_comb begin
    gnt_any = 1'b0;
    gnt = '0;
    for (int i = NUM_CH; i >= 1; i--)
      if (elig2[int'(last_g) + i]) begin
        gnt_any = 1'b1;
        gnt = CHW'((int'(last_g) + i) % NUM_CH);
      end
  end
  always_ff @(posedge clk)
    if (rst) last_g <= CHW'(NUM_CH - 1);
    else if (ok) last_g <= gnt;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      arvalid_m <= 1'b0;
      arid_m <= '0;
      araddr_m <= '0;
    end else if (ok) begin
      arvalid_m <= 1'b1;
      arid_m <= 16'(gnt);
      araddr_m <= ch_addr[gnt];
    end else if (arready_m) arvalid_m <= 1'b0;
  always_ff @(posedge clk) err <= rst ? 1'b0 : err | (rvalid_m & ~|push);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    st_t st, st_n;
    logic [ADDR_W-1:0] b, addr;
    logic [CNT_W-1:0] n, rem;
    logic [CNT_W:0] lines;
    logic [IW-1:0] off, idx;
    logic [CW-1:0] credit;
    logic [PW-1:0] wp, rp;
    logic [PW:0] cnt;
    logic [LINE_W-1:0] mem [DEPTH];
    logic go, fire, last, pop, dn;
    assign b = base_addr[c*ADDR_W +: ADDR_W];
    assign n = word_count[c*CNT_W +: CNT_W];
    assign off = IW'(b >> WB) & IW'(WPL - 1);
    assign go = start[c] && st == IDLE;
    assign fire = out_valid[c] && out_ready[c];
    assign last = rem == CNT_W'(1);
    assign pop = fire && (idx == IW'(WPL - 1) || last);
    assign busy[c] = st != IDLE;
    assign done[c] = dn;
    assign out_valid[c] = cnt != '0;
    assign out_data[c*WORD_W +: WORD_W] = mem[rp][idx*WORD_W +: WORD_W];
    // credit and line count move at grant time, so a held AR already counts as outstanding
    assign elig[c] = st == FETCH && credit < CW'(DEPTH);
    assign push[c] = rvalid_m && rid_m == 16'(c) && busy[c];
    assign ch_addr[c] = addr;
    always_comb
      st_n = go && n != '0 ? FETCH
           : fire && last ? IDLE
           : st == FETCH && issue[c] && lines == (CNT_W+1)'(1) ? DRAIN : st;
    always_ff @(posedge clk) st <= rst ? IDLE : st_n;
    always_ff @(posedge clk) if (push[c]) mem[wp] <= rdata_m;
    always_ff @(posedge clk)
      if (rst) begin
        addr <= '0;
        lines <= '0;
        rem <= '0;
        idx <= '0;
        credit <= '0;
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        dn <= 1'b0;
      end else begin
        dn <= (go && n == '0) || (fire && last);
        credit <= credit + CW'(issue[c]) - CW'(pop);
        cnt <= cnt + (PW+1)'(push[c]) - (PW+1)'(pop);
        wp <= wp + PW'(push[c]);
        rp <= rp + PW'(pop);
        if (go) begin
          addr <= b & ~ADDR_W'(LINE_W / 8 - 1);
          lines <= n == '0 ? '0 : ({1'b0, n} + (CNT_W+1)'(off) + (CNT_W+1)'(WPL - 1)) >> LW;
          rem <= n;
          idx <= off;
        end else begin
          if (issue[c]) begin
            addr <= addr + ADDR_W'(LINE_W / 8);
            lines <= lines - (CNT_W+1)'(1);
          end
          if (fire) begin
            rem <= rem - CNT_W'(1);
            idx <= pop ? '0 : idx + IW'(1);
          end
        end
      end
  end
endmodule

// File: tb/tb_multi_stream_reader.sv
// tb_multi_stream_reader: randomized AXI slave and word-level reference model for multi_stream_reader
module tb_multi_stream_reader;
  localparam int NC = 3, WW = 64, LWD = 512, AW = 64, DP = 4, CW = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic [NC-1:0] start = '0, out_ready = '0;
  logic [NC*AW-1:0] base_addr = '0;
  logic [NC*CW-1:0] word_count = '0;
  logic [NC-1:0] busy, done, out_valid;
  logic err, arvalid_m, rready_m;
  logic arready_m = 1'b0, rvalid_m = 1'b0;
  logic [15:0] arid_m, rid_m = '0;
  logic [AW-1:0] araddr_m;
  logic [7:0] arlen_m;
  logic [2:0] arsize_m;
  logic [LWD-1:0] rdata_m = '0;
  logic [NC*WW-1:0] out_data;

  multi_stream_reader #(.NUM_CH(NC), .WORD_W(WW), .LINE_W(LWD), .ADDR_W(AW), .DEPTH(DP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .err(err), .arid_m(arid_m), .araddr_m(araddr_m),
    .arlen_m(arlen_m), .arsize_m(arsize_m), .arvalid_m(arvalid_m), .arready_m(arready_m),
    .rid_m(rid_m), .rdata_m(rdata_m), .rvalid_m(rvalid_m), .rready_m(rready_m),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory content: every word carries its own byte address
  function automatic logic [63:0] wf(input logic [63:0] a);
    return {a[31:0] ^ 32'hdead_beef, a[31:0]};
  endfunction

  typedef struct {logic [15:0] id; logic [63:0] a;} beat_t;
  logic [63:0] exp_words [NC][$];
  logic [63:0] exp_ar [NC][$];
  int done_cnt [NC];
  int ar_cnt [NC];
  int or_mode [NC];
  logic [15:0] ar_log [$];
  beat_t rq [$];

  always @(negedge clk) begin
    beat_t b;
    int c;
    if (rst) begin
      rvalid_m = 1'b0;
      arready_m = 1'b0;
    end else begin
      if (rq.size() != 0 && $urandom_range(0, 3) != 0) begin
        b = rq.pop_front();
        rvalid_m = 1'b1;
        rid_m = b.id;
        for (int k = 0; k < 8; k++) rdata_m[k*64 +: 64] = wf(b.a + 64'(8 * k));
      end else rvalid_m = 1'b0;
      arready_m = $urandom_range(0, 2) != 0;
      for (int k = 0; k < NC; k++)
        out_ready[k] = or_mode[k] == 2 ? 1'($urandom_range(0, 1)) : or_mode[k] == 1;
      if (arvalid_m && arready_m) begin
        ar_log.push_back(arid_m);
        check("arsize", 64'(arsize_m), 64'd6);
        check("arlen", 64'(arlen_m), 64'd0);
        check("arid_range", 64'(arid_m < NC), 64'd1);
        if (arid_m < NC) begin
          c = int'(arid_m);
          ar_cnt[c]++;
          if (exp_ar[c].size() == 0) check($sformatf("ch%0d_ar_extra", c), 64'd0, 64'd1);
          else check($sformatf("ch%0d_araddr", c), araddr_m, exp_ar[c].pop_front());
        end
        rq.push_back('{arid_m, araddr_m});
      end
      for (int k = 0; k < NC; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_words[k].size() == 0) check($sformatf("ch%0d_word_extra", k), 64'd0, 64'd1);
          else check($sformatf("ch%0d_word", k), out_data[k*WW +: WW], exp_words[k].pop_front());
        end
        if (done[k]) done_cnt[k]++;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int c = 0; c < NC; c++) begin
      exp_words[c].delete();
      exp_ar[c].delete();
      done_cnt[c] = 0;
      ar_cnt[c] = 0;
    end
    rq.delete();
    ar_log.delete();
  endtask

  // expected words in address order; expected ARs are the distinct lines those words touch
  task automatic setup(input int c, input logic [63:0] base, input int n);
    logic [63:0] a, ln;
    base_addr[c*AW +: AW] = base;
    word_count[c*CW +: CW] = CW'(n);
    for (int i = 0; i < n; i++) begin
      a = base + 64'(8 * i);
      exp_words[c].push_back(wf(a));
      ln = {a[63:6], 6'b0};
      if (exp_ar[c].size() == 0 || exp_ar[c][$] != ln) exp_ar[c].push_back(ln);
    end
  endtask

  task automatic go(input logic [NC-1:0] m);
    start = m;
    tick();
    start = '0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((busy != '0 || rq.size() != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", 64'(t < budget), 64'd1);
    repeat (3) @(negedge clk);
    tick();
  endtask

  task automatic verify(input int c, input int nd);
    check($sformatf("ch%0d_words_left", c), 64'(exp_words[c].size()), 64'd0);
    check($sformatf("ch%0d_ar_left", c), 64'(exp_ar[c].size()), 64'd0);
    check($sformatf("ch%0d_done_cnt", c), 64'(done_cnt[c]), 64'(nd));
  endtask

  task automatic wait_err(input int budget);
    int t = 0;
    while (!err && t < budget) begin
      tick();
      t++;
    end
  endtask

  initial begin
    logic [NC-1:0] m;
    int e;
    for (int c = 0; c < NC; c++) or_mode[c] = 1;
    clear_model();
    tick(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_arvalid", 64'(arvalid_m), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    tick(2);

    setup(0, 64'h1000, 8);
    go(3'b001);
    wait_idle(500);
    verify(0, 1);
    check("ch0_ar_cnt", 64'(ar_cnt[0]), 64'd1);

    clear_model();
    or_mode[1] = 2;
    setup(1, 64'h2018, 7);
    go(3'b010);
    wait_idle(500);
    verify(1, 1);
    check("ch1_ar_cnt", 64'(ar_cnt[1]), 64'd2);

    clear_model();
    or_mode[2] = 0;
    setup(2, 64'h8000, 40);
    go(3'b100);
    tick(60);
    check("ch2_ar_capped", 64'(ar_cnt[2]), 64'(DP));
    check("ch2_arvalid_low", 64'(arvalid_m), 64'd0);
    check("ch2_out_valid", 64'(out_valid[2]), 64'd1);
    or_mode[2] = 1;
    wait_idle(2000);
    verify(2, 1);
    check("ch2_ar_cnt", 64'(ar_cnt[2]), 64'd5);

    clear_model();
    for (int c = 0; c < NC; c++) begin
      or_mode[c] = 1;
      setup(c, 64'(32'h10000 * (c + 1)), 16);
    end
    go(3'b111);
    wait_idle(2000);
    for (int c = 0; c < NC; c++) verify(c, 1);
    check("arb_len", 64'(ar_log.size()), 64'd6);
    for (int i = 0; i < ar_log.size() && i < 6; i++) begin
`ifdef MSR_FIXED_PRIO_EN
      e = i / 2;
`else
      e = i % 3;
`endif
      check($sformatf("arb_seq%0d", i), 64'(ar_log[i]), 64'(e));
    end

    clear_model();
    or_mode[0] = 0;
    setup(0, 64'h4000, 16);
    rq.push_back('{16'd5, 64'h0});
    go(3'b001);
    wait_err(50);
    check("err_bad_rid", 64'(err), 64'd1);
    check("busy_before_rst", 64'(busy[0]), 64'd1);
    rst = 1'b1;
    tick(2);
    clear_model();
    rst = 1'b0;
    tick();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    check("midrst_arvalid", 64'(arvalid_m), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    rq.push_back('{16'd0, 64'h4000});
    wait_err(50);
    check("err_idle_beat", 64'(err), 64'd1);
    rst = 1'b1;
    tick(2);
    clear_model();
    rst = 1'b0;
    or_mode[0] = 1;
    tick();

    or_mode[1] = 2;
    setup(1, 64'h6000, 16);
    go(3'b010);
    tick(3);
    check("ch1_busy", 64'(busy[1]), 64'd1);
    base_addr[1*AW +: AW] = 64'h9000;
    word_count[1*CW +: CW] = 3;
    setup(0, 64'h5000, 0);
    go(3'b011);
    check("zero_done_pulse", 64'(done[0]), 64'd1);
    check("zero_not_busy", 64'(busy[0]), 64'd0);
    tick();
    check("zero_done_low", 64'(done[0]), 64'd0);
    wait_idle(2000);
    verify(0, 1);
    verify(1, 1);
    check("zero_no_ar", 64'(ar_cnt[0]), 64'd0);

    for (int r = 0; r < 4; r++) begin
      clear_model();
      m = 3'($urandom_range(1, 7));
      for (int c = 0; c < NC; c++) begin
        or_mode[c] = $urandom_range(1, 2);
        if (m[c]) setup(c, 64'(32'h100000 * (c + 1) + 32'h1000 * r + 8 * $urandom_range(0, 15)),
                        $urandom_range(1, 30));
      end
      go(m);
      wait_idle(3000);
      for (int c = 0; c < NC; c++) verify(c, int'(m[c]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_stream_reader.md
Name: multi_stream_reader

Overview:
- Parametrised N-channel line reader for the PageRank engine. Generalises the single-stream read buffer.
- Each channel is given a base address and a word count. The block issues single-beat full-line AXI reads, tagging each with ARID = channel index.
- Read data is steered by RID into per-channel line buffers, then unpacked into WORD_W-wide words on independent valid/ready output streams.
- Handles unaligned start address, partial last line and per-channel credit-based flow control.

Parameters:
- NUM_CH, 3: number of independent read channels (1..8).
- WORD_W, 64: output word width in bits; power of two, ≤ LINE_W.
- LINE_W, 512: AXI data width and line size in bits.
- ADDR_W, 64: byte address width.
- DEPTH, 4: per-channel line-buffer depth; also the maximum outstanding plus buffered lines per channel (power of two).
- CNT_W, 32: word-count width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  NUM_CH  per-channel start pulse
- base_addr  in  NUM_CH*ADDR_W  per-channel byte base address; channel c occupies slice [c*ADDR_W +: ADDR_W]; must be WORD_W/8 aligned
- word_count  in  NUM_CH*CNT_W  per-channel number of words to read
- busy  out  NUM_CH  channel active
- done  out  NUM_CH  one-cycle pulse when channel completes
- err  out  1  sticky: an R beat had an invalid RID or was for an idle channel
- arid_m  out  16  channel index
- araddr_m  out  ADDR_W  line-aligned address
- arlen_m  out  8  always 0
- arsize_m  out  3  log2(LINE_W/8)
- arvalid_m  out  1
- arready_m  in  1
- rid_m  in  16
- rdata_m  in  LINE_W
- rvalid_m  in  1
- rready_m  out  1  constant 1
- out_valid  out  NUM_CH
- out_data  out  NUM_CH*WORD_W
- out_ready  in  NUM_CH

Behaviour:
- Reset: busy=0, done=0, err=0, arvalid_m=0, out_valid=0. All buffers, credits and counters cleared. Reset mid-operation abandons all transfers. Beats arriving later for idle channels are discarded and set err.
- Definitions: WPL = LINE_W/WORD_W; OB = log2(LINE_W/8); WB = log2(WORD_W/8).
- Start (channel idle):
  - Latch off = base[OB-1:WB], rem = count.
  - lines = (off + count + WPL-1) >> log2(WPL).
  - addr = base with bits [OB-1:0] cleared.
  - busy set the next cycle.
- Start edge cases:
  - start while busy: ignored.
  - count=0: no reads; busy stays 0; done pulses on the cycle after start.
- Per-channel state: IDLE -> FETCH (lines>0) -> DRAIN (all ARs accepted) -> IDLE (last word accepted).
- Credit: credit = outstanding ARs + buffered lines. A channel is AR-eligible when in FETCH and credit < DEPTH.
- Arbiter:
  - Default is round-robin over eligible channels, starting after the last granted channel.
  - A grant latches arid/araddr and raises arvalid_m. These are held stable until arready_m.
  - On the handshake: addr += LINE_W/8, lines--, credit++. A new grant may be made in the next cycle (max one AR per 2 cycles is acceptable; back-to-back is preferred).
- R path:
  - rready_m is always 1; credits guarantee buffer space.
  - A beat with rid<NUM_CH and that channel busy is pushed into its line buffer the same cycle.
  - A beat with rid≥NUM_CH, or for an idle channel, is dropped and sets err.
- Unpacker, per channel:
  - out_valid is high when its buffer is non-empty; this gives one cycle of latency from an R beat to out_valid.
  - out_data = head line word [idx*WORD_W +: WORD_W]; idx starts at off for the first line and at 0 otherwise; lowest word first.
  - On out_valid & out_ready: idx++, rem--.
  - The line is popped and credit-- when idx reaches WPL-1 or rem reaches 1.
  - Words of a partial last line beyond rem are never presented.
- Completion: on acceptance of the final word, busy=0 and done pulses the next cycle. A same-cycle start on that channel is ignored.
- Simultaneous push and pop on one buffer are both performed. Channels are fully independent.

Optional Feature:
- MSR_FIXED_PRIO_EN: when defined, the arbiter uses fixed priority, with the lowest eligible channel index winning.
- When undefined, the arbiter is round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Ch0 base=0x1000, count=8, out_ready=1 -> one AR: araddr=0x1000, arid=0, arsize=6. Words 0..7 appear in order. done[0] pulses once.
- Ch1 base=0x2018 (off=3), count=7 -> 2 ARs: 0x2000, 0x2040. Outputs are line0 words 3..7, then line1 words 0..1. No extra words.
- Ch2 count=40, out_ready=0 -> exactly DEPTH=4 ARs are issued, then arvalid stays 0. Releasing out_ready resumes fetching; all 40 words are delivered.
- All 3 channels started together with count=16, arready random -> round-robin ARID sequence 0,1,2,0,1,2. With MSR_FIXED_PRIO_EN, ARID sequence is 0,0,1,1,2,2 (credits permitting).
- R beat with rid=5, then rst asserted mid-transfer -> err=1 after the beat. After rst: busy=0, err=0, arvalid=0. A late beat for idle ch0 sets err=1.
- Start with count=0 on ch0; also start pulsed on busy ch1 -> done[0] pulses one cycle later with no AR. Ch1's transfer is unaffected.
